// File: rtl/btle_txrx_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btle_txrx_sequencer_if : command, PHY TX/RX and status bundle for the    |
// |                          BTLE TX/RX sequencer                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface btle_txrx_sequencer_if #(
  parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int CRC_STATE_BIT_WIDTH      = 24,
  parameter int TIMER_BIT_WIDTH          = 16
);
  logic                                cmd_valid;
  logic                                cmd_ready;
  logic                                cmd_rx_after_tx;
  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] cmd_channel;
  logic [CRC_STATE_BIT_WIDTH-1:0]      cmd_crc_init;
  logic [TIMER_BIT_WIDTH-1:0]          cmd_rx_timeout;
  logic                                abort;

  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] tx_channel_number;
  logic                                tx_channel_number_load;
  logic [CRC_STATE_BIT_WIDTH-1:0]      tx_crc_state_init_bit;
  logic                                tx_crc_state_init_bit_load;
  logic                                tx_start;
  logic                                tx_iq_valid_last;

  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] rx_channel_number;
  logic [CRC_STATE_BIT_WIDTH-1:0]      rx_crc_state_init_bit;
  logic                                rx_enable;
  logic                                rx_hit_flag;
  logic                                rx_decode_end;
  logic                                rx_crc_ok;

  logic                                busy;
  logic                                done;
  logic [1:0]                          status;
  logic [15:0]                         stat_tx_cnt;
  logic [15:0]                         stat_rx_ok_cnt;
  logic [15:0]                         stat_rx_fail_cnt;
  logic [15:0]                         stat_timeout_cnt;

  modport master (
    output cmd_valid, cmd_rx_after_tx, cmd_channel, cmd_crc_init, cmd_rx_timeout, abort,
    output tx_iq_valid_last, rx_hit_flag, rx_decode_end, rx_crc_ok,
    input  cmd_ready, tx_channel_number, tx_channel_number_load, tx_crc_state_init_bit,
    input  tx_crc_state_init_bit_load, tx_start, rx_channel_number, rx_crc_state_init_bit,
    input  rx_enable, busy, done, status,
    input  stat_tx_cnt, stat_rx_ok_cnt, stat_rx_fail_cnt, stat_timeout_cnt
  );

  modport slave (
    input  cmd_valid, cmd_rx_after_tx, cmd_channel, cmd_crc_init, cmd_rx_timeout, abort,
    input  tx_iq_valid_last, rx_hit_flag, rx_decode_end, rx_crc_ok,
    output cmd_ready, tx_channel_number, tx_channel_number_load, tx_crc_state_init_bit,
    output tx_crc_state_init_bit_load, tx_start, rx_channel_number, rx_crc_state_init_bit,
    output rx_enable, busy, done, status,
    output stat_tx_cnt, stat_rx_ok_cnt, stat_rx_fail_cnt, stat_timeout_cnt
  );
endinterface
`default_nettype wire

// File: rtl/btle_txrx_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btle_txrx_sequencer : TX-then-optional-RX sequencer with IFS timing;     |
// |                       statistics counters built when BTLE_SEQ_STATS_EN   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module btle_txrx_sequencer #(
  parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int CRC_STATE_BIT_WIDTH      = 24,
  parameter int TIMER_BIT_WIDTH          = 16,
  parameter int T_IFS_CYCLES             = 2400
) (
  input wire                   clk,
  input wire                   rst,
  btle_txrx_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    TX_WAIT   = 3'd3,
    IFS       = 3'd4,
    RX_SEARCH = 3'd5,
    RX_DECODE = 3'd6,
    DONE      = 3'd7
  } state_e;

  localparam logic [TIMER_BIT_WIDTH-1:0] c_ifs_load  = TIMER_BIT_WIDTH'(T_IFS_CYCLES - 1);
  localparam logic [TIMER_BIT_WIDTH-1:0] c_timer_one = TIMER_BIT_WIDTH'(1);

  state_e                              state_q;
  logic [TIMER_BIT_WIDTH-1:0]          timer_q;
  logic [TIMER_BIT_WIDTH-1:0]          timeout_q;
  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_q;
  logic [CRC_STATE_BIT_WIDTH-1:0]      crc_q;
  logic                                rx_after_tx_q;
  logic                                cmd_ready_q;
  logic                                busy_q;
  logic                                done_q;
  logic                                rx_enable_q;
  logic                                tx_start_q;
  logic                                tx_load_q;
  logic [1:0]                          status_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      timeout_q     <= '0;
      channel_q     <= '0;
      crc_q         <= '0;
      rx_after_tx_q <= 1'b0;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rx_enable_q   <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_load_q     <= 1'b0;
      status_q      <= 2'b00;
    end else begin
      done_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_load_q  <= 1'b0;
      if (state_q != IDLE && bus.abort) begin
        state_q     <= IDLE;
        cmd_ready_q <= 1'b1;
        busy_q      <= 1'b0;
        rx_enable_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            cmd_ready_q <= 1'b1;
            if (bus.cmd_valid && cmd_ready_q && !bus.abort) begin
              channel_q     <= bus.cmd_channel;
              crc_q         <= bus.cmd_crc_init;
              timeout_q     <= bus.cmd_rx_timeout;
              rx_after_tx_q <= bus.cmd_rx_after_tx;
              cmd_ready_q   <= 1'b0;
              busy_q        <= 1'b1;
              tx_load_q     <= 1'b1;
              state_q       <= LOAD;
            end
          end
          LOAD: begin
            tx_start_q <= 1'b1;
            state_q    <= START;
          end
          START: state_q <= TX_WAIT;
          TX_WAIT: begin
            if (bus.tx_iq_valid_last) begin
              if (rx_after_tx_q) begin
                timer_q <= c_ifs_load;
                state_q <= IFS;
              end else begin
                status_q <= 2'b00;
                done_q   <= 1'b1;
                state_q  <= DONE;
              end
            end
          end
          IFS: begin
            // Leave on the edge where the count would hit zero so the window
            // opens T_IFS_CYCLES cycles after the last TX sample.
            if (timer_q <= c_timer_one) begin
              timer_q     <= timeout_q;
              rx_enable_q <= 1'b1;
              state_q     <= RX_SEARCH;
            end else begin
              timer_q <= timer_q - c_timer_one;
            end
          end
          RX_SEARCH: begin
            if (bus.rx_hit_flag) begin
              state_q <= RX_DECODE;
            end else if (timer_q == '0) begin
              status_q    <= 2'b11;
              done_q      <= 1'b1;
              rx_enable_q <= 1'b0;
              state_q     <= DONE;
            end else begin
              timer_q <= timer_q - c_timer_one;
            end
          end
          RX_DECODE: begin
            if (bus.rx_decode_end) begin
              status_q    <= bus.rx_crc_ok ? 2'b01 : 2'b10;
              done_q      <= 1'b1;
              rx_enable_q <= 1'b0;
              state_q     <= DONE;
            end
          end
          DONE: begin
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.cmd_ready                  = cmd_ready_q;
  assign bus.busy                       = busy_q;
  assign bus.done                       = done_q;
  assign bus.status                     = status_q;
  assign bus.rx_enable                  = rx_enable_q;
  assign bus.tx_start                   = tx_start_q;
  assign bus.tx_channel_number_load     = tx_load_q;
  assign bus.tx_crc_state_init_bit_load = tx_load_q;
  assign bus.tx_channel_number          = channel_q;
  assign bus.rx_channel_number          = channel_q;
  assign bus.tx_crc_state_init_bit      = crc_q;
  assign bus.rx_crc_state_init_bit      = crc_q;

`ifdef BTLE_SEQ_STATS_EN
  logic [15:0] stat_tx_q;
  logic [15:0] stat_ok_q;
  logic [15:0] stat_fail_q;
  logic [15:0] stat_to_q;

  // Status is valid in the same cycle as the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_tx_q   <= '0;
      stat_ok_q   <= '0;
      stat_fail_q <= '0;
      stat_to_q   <= '0;
    end else begin
      if (tx_start_q && stat_tx_q != 16'hFFFF) stat_tx_q <= stat_tx_q + 16'd1;
      if (done_q) begin
        case (status_q)
          2'b01:   if (stat_ok_q   != 16'hFFFF) stat_ok_q   <= stat_ok_q   + 16'd1;
          2'b10:   if (stat_fail_q != 16'hFFFF) stat_fail_q <= stat_fail_q + 16'd1;
          2'b11:   if (stat_to_q   != 16'hFFFF) stat_to_q   <= stat_to_q   + 16'd1;
          default: ;
        endcase
      end
    end
  end

  assign bus.stat_tx_cnt      = stat_tx_q;
  assign bus.stat_rx_ok_cnt   = stat_ok_q;
  assign bus.stat_rx_fail_cnt = stat_fail_q;
  assign bus.stat_timeout_cnt = stat_to_q;
`else
  assign bus.stat_tx_cnt      = 16'h0000;
  assign bus.stat_rx_ok_cnt   = 16'h0000;
  assign bus.stat_rx_fail_cnt = 16'h0000;
  assign bus.stat_timeout_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btle_txrx_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_btle_txrx_sequencer : scoreboard bench for btle_txrx_sequencer         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_btle_txrx_sequencer;

  localparam int T_IFS = 2400;
`ifdef BTLE_SEQ_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  btle_txrx_sequencer_if bus ();

  btle_txrx_sequencer #(.T_IFS_CYCLES(T_IFS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0]  exp_status_q[$];
  int          exp_rise_q[$];
  int          exp_len_q[$];
  logic [29:0] exp_load_q[$];

  int       last_txlast_cyc = 0;
  int       rise_cyc = 0;
  int       load_cyc = 0;
  bit       prev_rx_en = 1'b0;
  bit       skip_fall = 1'b0;
  bit       stats_pending = 1'b0;
  int       m_tx = 0, m_ok = 0, m_fail = 0, m_to = 0;
  logic [1:0] m_last_status = 2'b00;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: outcome and RX window length from the command/stimulus.
  function automatic logic [1:0] model_status(input bit rx_after, input int timeout,
                                              input int hit_off, input bit crc_ok);
    if (!rx_after) return 2'b00;
    if (hit_off > timeout) return 2'b11;
    return crc_ok ? 2'b01 : 2'b10;
  endfunction

  function automatic int model_window(input int timeout, input int hit_off, input int dec_d);
    return (hit_off > timeout) ? timeout + 1 : hit_off + 2 + dec_d;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      m_tx = 0; m_ok = 0; m_fail = 0; m_to = 0;
      m_last_status = 2'b00;
      stats_pending = 1'b0;
    end else begin
      if (stats_pending) begin
        stats_pending = 1'b0;
        chk("stat_tx_cnt",      bus.stat_tx_cnt,      STATS_EN ? m_tx   : 0);
        chk("stat_rx_ok_cnt",   bus.stat_rx_ok_cnt,   STATS_EN ? m_ok   : 0);
        chk("stat_rx_fail_cnt", bus.stat_rx_fail_cnt, STATS_EN ? m_fail : 0);
        chk("stat_timeout_cnt", bus.stat_timeout_cnt, STATS_EN ? m_to   : 0);
      end
      if (bus.tx_channel_number_load) begin
        if (exp_load_q.size() == 0) chk("unexpected_load", 1, 0);
        else begin
          logic [29:0] e;
          e = exp_load_q.pop_front();
          chk("tx_channel_number",     bus.tx_channel_number,     e[29:24]);
          chk("rx_channel_number",     bus.rx_channel_number,     e[29:24]);
          chk("tx_crc_state_init_bit", bus.tx_crc_state_init_bit, e[23:0]);
          chk("rx_crc_state_init_bit", bus.rx_crc_state_init_bit, e[23:0]);
          chk("crc_load_pulse",        bus.tx_crc_state_init_bit_load, 1);
          m_tx++;
        end
        load_cyc = cyc;
      end
      if (bus.tx_start) chk("start_after_load", cyc - load_cyc, 1);
      if (bus.done) begin
        if (exp_status_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          logic [1:0] st;
          st = exp_status_q.pop_front();
          chk("status", bus.status, st);
          chk("busy_in_done", bus.busy, 1);
          m_last_status = st;
          case (st)
            2'b01: m_ok++;
            2'b10: m_fail++;
            2'b11: m_to++;
            default: ;
          endcase
          stats_pending = 1'b1;
        end
      end
    end
    if (bus.rx_enable && !prev_rx_en) begin
      if (exp_rise_q.size() == 0) chk("unexpected_rx_window", 1, 0);
      else chk("ifs_gap", cyc - last_txlast_cyc, exp_rise_q.pop_front());
      rise_cyc = cyc;
    end
    if (!bus.rx_enable && prev_rx_en) begin
      if (skip_fall) skip_fall = 1'b0;
      else if (exp_len_q.size() == 0) chk("unexpected_rx_close", 1, 0);
      else chk("rx_window_len", cyc - rise_cyc, exp_len_q.pop_front());
    end
    prev_rx_en = bus.rx_enable;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_noise();
    bus.rx_hit_flag      = 1'b0;
    bus.rx_decode_end    = 1'b0;
    bus.tx_iq_valid_last = 1'b0;
  endtask

  // PHY inputs toggled where the sequencer is not waiting for them.
  task automatic drive_noise(input int mode);
    bus.rx_hit_flag   = 1'($urandom_range(0, 1));
    bus.rx_decode_end = 1'($urandom_range(0, 1));
    bus.rx_crc_ok     = 1'($urandom_range(0, 1));
    if (mode == 2) bus.tx_iq_valid_last = 1'($urandom_range(0, 1));
  endtask

  function automatic bit sig_of(input int which);
    case (which)
      0:       return bus.tx_start;
      1:       return bus.rx_enable;
      2:       return !bus.rx_enable;
      default: return bus.cmd_ready;
    endcase
  endfunction

  task automatic wait_for(input int which, input int limit, input int noise,
                          input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (sig_of(which)) begin
        ok = 1'b1;
        break;
      end
      if (noise != 0) drive_noise(noise);
      tick();
    end
    clear_noise();
    if (!ok) chk({"wait_", name}, 0, 1);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_rx_enable"}, bus.rx_enable, 0);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_done"},      bus.done, 0);
    chk({tag, "_status"},    bus.status, m_last_status);
  endtask

  task automatic reset_mid();
    skip_fall = 1'b1;
    rst = 1'b0;
    #2;
    chk("rst_busy",      bus.busy, 0);
    chk("rst_rx_enable", bus.rx_enable, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_done",      bus.done, 0);
    chk("rst_status",    bus.status, 0);
    chk("rst_stat_tx",   bus.stat_tx_cnt, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_cmd_ready", bus.cmd_ready, 1);
    chk("post_rst_done",      bus.done, 0);
    chk("post_rst_rx_enable", bus.rx_enable, 0);
  endtask

  // abort_mode: 0 none, 1 abort in TX_WAIT, 2 abort in IFS
  task automatic run_txn(input bit rx_after, input logic [5:0] ch, input logic [23:0] crc,
                         input int tx_delay, input int timeout, input int hit_off,
                         input int dec_d, input bit crc_ok, input int abort_mode,
                         input int abort_at, input bit rst_in_decode);
    bit ok;
    bit hit;
    hit = (hit_off <= timeout);
    wait_for(3, 5000, 0, "cmd_ready", ok);
    if (!ok) return;
    repeat (1 + $urandom_range(0, 2)) tick();
    bus.cmd_valid       = 1'b1;
    bus.cmd_rx_after_tx = rx_after;
    bus.cmd_channel     = ch;
    bus.cmd_crc_init    = crc;
    bus.cmd_rx_timeout  = 16'(timeout);
    exp_load_q.push_back({ch, crc});
    if (abort_mode == 0 && !rst_in_decode)
      exp_status_q.push_back(model_status(rx_after, timeout, hit_off, crc_ok));
    if (rx_after && abort_mode == 0) exp_rise_q.push_back(T_IFS);
    if (rx_after && abort_mode == 0 && !rst_in_decode)
      exp_len_q.push_back(model_window(timeout, hit_off, dec_d));
    tick();
    bus.cmd_valid       = 1'b0;
    bus.cmd_rx_after_tx = 1'($urandom_range(0, 1));
    bus.cmd_channel     = 6'($urandom);
    bus.cmd_crc_init    = 24'($urandom);
    bus.cmd_rx_timeout  = 16'($urandom);
    wait_for(0, 10, 1, "tx_start", ok);
    if (!ok) return;
    if (abort_mode == 1) begin
      repeat (abort_at) begin drive_noise(1); tick(); end
      clear_noise();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check_idle("abort_txwait");
      return;
    end
    repeat (tx_delay) begin drive_noise(1); tick(); end
    clear_noise();
    bus.tx_iq_valid_last = 1'b1;
    last_txlast_cyc = cyc;
    tick();
    bus.tx_iq_valid_last = 1'b0;
    if (!rx_after) return;
    if (abort_mode == 2) begin
      repeat (abort_at) begin drive_noise(2); tick(); end
      clear_noise();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check_idle("abort_ifs");
      return;
    end
    wait_for(1, T_IFS + 20, 2, "rx_window_open", ok);
    if (!ok) return;
    if (hit) begin
      repeat (hit_off) tick();
      bus.rx_hit_flag = 1'b1;
      tick();
      bus.rx_hit_flag = 1'b0;
      repeat (dec_d) tick();
      if (rst_in_decode) begin
        reset_mid();
        return;
      end
      bus.rx_decode_end = 1'b1;
      bus.rx_crc_ok     = crc_ok;
      tick();
      bus.rx_decode_end = 1'b0;
      bus.rx_crc_ok     = 1'($urandom_range(0, 1));
    end else begin
      wait_for(2, timeout + 10, 0, "rx_window_close", ok);
    end
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got no completion, expected finish within 90000 cycles");
    $fatal(1);
  end

  initial begin
    bit         ra;
    int         to;
    int         ho;
    bus.cmd_valid = 1'b0; bus.cmd_rx_after_tx = 1'b0; bus.cmd_channel = '0;
    bus.cmd_crc_init = '0; bus.cmd_rx_timeout = '0; bus.abort = 1'b0;
    bus.tx_iq_valid_last = 1'b0; bus.rx_hit_flag = 1'b0; bus.rx_decode_end = 1'b0;
    bus.rx_crc_ok = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", bus.cmd_ready, 0);
    chk("reset_busy",      bus.busy, 0);
    chk("reset_done",      bus.done, 0);
    chk("reset_status",    bus.status, 0);
    chk("reset_rx_enable", bus.rx_enable, 0);
    chk("reset_tx_start",  bus.tx_start, 0);
    chk("reset_tx_load",   bus.tx_channel_number_load, 0);
    chk("reset_channel",   bus.tx_channel_number, 0);
    chk("reset_stat_fail", bus.stat_rx_fail_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    @(negedge clk);
    chk("first_cycle_cmd_ready", bus.cmd_ready, 1);

    // TX only
    run_txn(1'b0, 6'd37, 24'h555555, 100, 0, 1, 0, 1'b0, 0, 0, 1'b0);
    // RX hit, CRC ok
    run_txn(1'b1, 6'd12, 24'hABCDEF, 20, 40, 10, 5, 1'b1, 0, 0, 1'b0);
    // RX timeout 50, no hit
    run_txn(1'b1, 6'd3, 24'h123456, 7, 50, 60, 0, 1'b0, 0, 0, 1'b0);
    // Hit on the final timer=0 cycle
    run_txn(1'b1, 6'd39, 24'h0F0F0F, 5, 50, 50, 2, 1'b1, 0, 0, 1'b0);
    // CRC fail
    run_txn(1'b1, 6'd20, 24'hFFFFFF, 9, 20, 3, 4, 1'b0, 0, 0, 1'b0);
    // Zero timeout: one-cycle window, with and without a hit
    run_txn(1'b1, 6'd1, 24'h000001, 3, 0, 1, 0, 1'b0, 0, 0, 1'b0);
    run_txn(1'b1, 6'd2, 24'h000002, 3, 0, 0, 0, 1'b1, 0, 0, 1'b0);
    // Aborts in TX_WAIT and IFS
    run_txn(1'b0, 6'd8, 24'h888888, 30, 0, 1, 0, 1'b0, 1, 12, 1'b0);
    run_txn(1'b1, 6'd9, 24'h999999, 4, 10, 2, 1, 1'b1, 2, 500, 1'b0);
    // Abort alongside cmd_valid in IDLE: ignored, command not accepted
    tick();
    bus.cmd_valid = 1'b1;
    bus.abort     = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    bus.abort     = 1'b0;
    check_idle("idle_abort");

    for (int i = 0; i < 8; i++) begin
      ra = 1'($urandom_range(0, 1));
      to = $urandom_range(0, 40);
      ho = $urandom_range(0, to + 8);
      run_txn(ra, 6'($urandom_range(0, 39)), 24'($urandom), $urandom_range(1, 30), to, ho,
              $urandom_range(0, 12), 1'($urandom_range(0, 1)), 0, 0, 1'b0);
    end

    // Reset while in RX_DECODE, then a normal TX after recovery
    run_txn(1'b1, 6'd30, 24'h3C3C3C, 6, 30, 5, 6, 1'b1, 0, 0, 1'b1);
    run_txn(1'b0, 6'd31, 24'hC3C3C3, 15, 0, 1, 0, 1'b0, 0, 0, 1'b0);

    repeat (20) tick();
    chk("pending_done",   exp_status_q.size(), 0);
    chk("pending_rise",   exp_rise_q.size(), 0);
    chk("pending_window", exp_len_q.size(), 0);
    chk("pending_load",   exp_load_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btle_txrx_sequencer.md
BTLE_TXRX_SEQUENCER -- requirements
Module: btle_txrx_sequencer

Interface
REQ-001 SHALL have parameter CHANNEL_NUMBER_BIT_WIDTH, default 6, which sets the channel field width.
REQ-002 SHALL have parameter CRC_STATE_BIT_WIDTH, default 24, which sets the CRC init width.
REQ-003 SHALL have parameter TIMER_BIT_WIDTH, default 16, which sets the IFS and RX timeout counter width.
REQ-004 SHALL have parameter T_IFS_CYCLES, default 2400, which sets the clk cycles between the end of TX and the opening of the RX window.
REQ-005 SHALL have ports clk (in, 1, single clock) and rst (in, 1, reset); reset is asynchronous and active-low.
REQ-006 SHALL have command ports:
- cmd_valid in 1
- cmd_ready out 1
- cmd_rx_after_tx in 1 (0 = TX only, 1 = TX then RX)
- cmd_channel in CHANNEL_NUMBER_BIT_WIDTH
- cmd_crc_init in CRC_STATE_BIT_WIDTH
- cmd_rx_timeout in TIMER_BIT_WIDTH
- abort in 1
REQ-007 SHALL have PHY TX ports:
- tx_channel_number out CHANNEL_NUMBER_BIT_WIDTH
- tx_channel_number_load out 1
- tx_crc_state_init_bit out CRC_STATE_BIT_WIDTH
- tx_crc_state_init_bit_load out 1
- tx_start out 1
- tx_iq_valid_last in 1
REQ-008 SHALL have PHY RX ports:
- rx_channel_number out CHANNEL_NUMBER_BIT_WIDTH
- rx_crc_state_init_bit out CRC_STATE_BIT_WIDTH
- rx_enable out 1 (gates rx_iq_valid)
- rx_hit_flag in 1
- rx_decode_end in 1
- rx_crc_ok in 1
REQ-009 SHALL have status ports:
- busy out 1
- done out 1 (single-cycle pulse)
- status out 2: 00 TX done, 01 RX CRC ok, 10 RX CRC fail, 11 RX timeout
- stat_tx_cnt, stat_rx_ok_cnt, stat_rx_fail_cnt, stat_timeout_cnt, each out 16

Function
REQ-010 SHALL implement the FSM states IDLE, LOAD, START, TX_WAIT, IFS, RX_SEARCH, RX_DECODE, DONE.
REQ-011 SHALL assert cmd_ready only in IDLE, and SHALL accept a command when cmd_valid && cmd_ready.
- On acceptance, all cmd_* fields are latched and the FSM moves to LOAD.
REQ-012 SHALL, in LOAD (1 cycle):
- drive the latched channel and CRC init on both tx_* and rx_* outputs;
- pulse tx_channel_number_load and tx_crc_state_init_bit_load high for exactly this cycle;
- then move to START.
REQ-013 SHALL pulse tx_start for exactly 1 cycle in START, then move to TX_WAIT.
REQ-014 SHALL, in TX_WAIT, wait for tx_iq_valid_last:
- if cmd_rx_after_tx = 0, go to DONE with status 00;
- otherwise, load the timer with T_IFS_CYCLES-1 and go to IFS.
REQ-015 SHALL decrement the timer each cycle in IFS, and SHALL go to RX_SEARCH when the timer reaches 0.
- The RX window therefore opens exactly T_IFS_CYCLES cycles after the tx_iq_valid_last cycle.
REQ-016 SHALL, on entry to RX_SEARCH, load the timer with the latched rx_timeout and hold rx_enable high throughout RX_SEARCH and RX_DECODE.
REQ-017 SHALL, in RX_SEARCH:
- go to RX_DECODE on rx_hit_flag;
- otherwise go to DONE with status 11 when the timer is 0, else decrement the timer.
- rx_hit_flag wins over a simultaneous timeout.
- A timeout value of 0 gives a 1-cycle window.
REQ-018 SHALL, in RX_DECODE, wait for rx_decode_end with no timeout, then go to DONE with status 01 if rx_crc_ok, else 10.
REQ-019 SHALL, in DONE (1 cycle), pulse done, hold status until the next DONE, then return to IDLE.
REQ-020 SHALL assert busy in every state except IDLE.
REQ-021 SHALL, when abort is high in any non-IDLE state, go to IDLE next cycle with:
- no done pulse;
- rx_enable low;
- status unchanged.
- abort has priority over all other transitions.
- abort in IDLE is ignored, and cmd_valid is not accepted in the same cycle as abort.
REQ-022 SHALL ignore PHY inputs (tx_iq_valid_last, rx_hit_flag, rx_decode_end, rx_crc_ok) in any state where they are not awaited.

Reset
REQ-023 SHALL, on rst low, asynchronously force the FSM to IDLE and all outputs, timer and counters to 0; cmd_ready is 1 from the first cycle after rst deasserts.

Configuration
REQ-024 SHALL compile the statistics counters only when macro BTLE_SEQ_STATS_EN is defined:
- stat_tx_cnt increments on each tx_start;
- the other three counters increment on DONE with status 01, 10 and 11 respectively;
- all four saturate at 16'hFFFF.
- Without the macro, the four stat ports are tied to 0 and no counter registers exist.

Verification
REQ-025 SHALL cover TX only: channel 37, crc_init 24'h555555, tx_iq_valid_last 100 cycles after tx_start -> one load pulse each, one tx_start, done with status 00.
REQ-026 SHALL cover RX hit: rx_after_tx=1, T_IFS_CYCLES=2400, hit 10 cycles into the window, decode_end with crc_ok=1 -> rx_enable rises exactly 2400 cycles after tx_iq_valid_last, status 01.
REQ-027 SHALL cover RX timeout: rx_timeout=50, no hit -> rx_enable high for 51 cycles, done with status 11; also with the hit on the final timer=0 cycle -> RX_DECODE.
REQ-028 SHALL cover CRC fail plus stats: decode_end with crc_ok=0 -> status 10, stat_rx_fail_cnt=1 with the macro defined, stat ports 0 without it.
REQ-029 SHALL cover abort and reset: abort in IFS, and separately rst low in RX_DECODE -> IDLE, no done, rx_enable 0, cmd_ready 1 on the next cycle.
